core_seq: RTL
=============

# core_seq

Multi-cycle sequencer for the RV32I core; the next generation after the single-cycle datapath. It owns the PC, instruction register and phase state machine, and talks to instruction and data memories over req/ready handshakes, so memories of any latency can be attached. The existing decoder, execute, register-file and data-path logic stay combinational around it. Write strobes (register and data memory) are issued only in their phase.

## Interface
Parameters:
- XLEN, 32, width of PC, addresses and data
- RESET_PC, 32'h0000_0000, PC loaded on reset
- NOP, 32'h0000_0013, IR value on reset (addi x0,x0,0)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset (low = reset)
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- ir  out  32  latched instruction, feeds decoder
- pc  out  XLEN  current PC, feeds execute
- is_load, is_store, is_halt, reg_we  in  1 each  decoder outputs for ir
- npc  in  XLEN  next PC from execute
- dmem_req  out  1  data access request (load or store)
- dmem_we  out  1  store strobe, valid only with dmem_req
- dmem_ready  in  1  data access complete
- dmem_rdata  in  XLEN  load data
- mdr  out  XLEN  latched load data for write-back mux
- rf_we  out  1  register-file write strobe (commit)
- instret  out  XLEN  retired-instruction count
- halted  out  1  core stopped

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT (plus TRAP when configured).
- FETCH: imem_req=1, imem_addr=pc. On imem_ready: ir<=imem_rdata, go DECODE.
- DECODE: one cycle; decoder/register file settle on new ir.
- EXEC: is_halt -> HALT; else is_load|is_store -> MEM; else WB.
- MEM: dmem_req=1, dmem_we=is_store. On dmem_ready: if is_load, mdr<=dmem_rdata; go WB.
- WB: rf_we=reg_we for exactly this cycle; pc<=npc; instret<=instret+1 (wraps modulo 2^XLEN); go FETCH.
- HALT: absorbing; halted=1, no requests, pc/ir/instret frozen; exits only via reset.
- A halt instruction is not counted in instret.
- rf_we, dmem_req and imem_req are never high outside their state.

## Timing
- Reset values: pc=RESET_PC, ir=NOP, mdr=0, instret=0, state=FETCH, all strobes 0, halted=0.
- Reset asserted mid-operation: state and registers clear asynchronously; requests drop in the same cycle; any outstanding ready is ignored.
- Handshake: req and addr/we held stable until the ready cycle; ready while req=0 is ignored; ready in the first req cycle is allowed (zero wait).
- Minimum latency: ALU/branch instruction 4 cycles (FETCH, DECODE, EXEC, WB); load/store 5 cycles; each memory wait cycle adds 1.
- pc updates on the clock edge ending WB; imem_addr shows the new pc in the next FETCH cycle.

## Configuration
- CORE_SEQ_MISALIGN_TRAP_EN defined: in WB, if npc[1:0]!=0, the state goes to TRAP instead of FETCH.
  - No pc update; rf_we is still issued; instret is still incremented.
  - TRAP behaves like HALT (halted=1).
- CORE_SEQ_MISALIGN_TRAP_EN not defined: no TRAP state; pc<=npc with the low bits untouched.

## Structure
- State encodings, NOP and RESET_PC defaults go in define.vh as shared constants.
- Sub-module core_seq_fsm: state register and next-state logic only.
  - Inputs: handshake and decoder flags.
  - Outputs: one-hot phase enables.
- The top holds the pc, ir, mdr and instret registers.

## Test plan
- Reset with RESET_PC=32'h100, release; imem_ready tied 1, addi program -> imem_addr=0x100 first cycle; rf_we pulse every 4 cycles; instret=3 after 3 instructions.
- imem_ready delayed 3 cycles -> imem_req and imem_addr stable 4 cycles; ir updates only on the ready edge.
- lw with dmem_ready after 2 waits, dmem_rdata=0xDEADBEEF -> mdr=0xDEADBEEF; rf_we 1 cycle; instruction takes 7 cycles.
- sw -> dmem_we=1 with dmem_req; rf_we stays 0 (reg_we=0); pc+4 after WB.
- halt instruction -> halted=1 from the cycle after EXEC; no further requests for 20 cycles; instret unchanged. Then rst low for 1 cycle -> pc=RESET_PC, halted=0.
- With CORE_SEQ_MISALIGN_TRAP_EN, jalr giving npc=0x102 -> halted=1; pc holds the jalr address; instret incremented. Without the macro -> fetch from 0x102.

Source files
------------

// File: rtl/core_seq_pkg.sv
// ============================================================================
// Module : core_seq_pkg
// Brief  : Shared constants, phase encoding and phase decode for core_seq.
//          Optional feature macro: CORE_SEQ_MISALIGN_TRAP_EN (adds TRAP).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_seq_pkg;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
`else
        S_HALT   = 3'd5
`endif
    } state_t;

    // Phase enables seen by the datapath; the DECODE and EXEC phases drive nothing.
    typedef struct packed {
        logic fetch;
        logic mem;
        logic wb;
        logic stop;
    } phase_t;

    function automatic phase_t phase_of(input state_t s);
        phase_t p;
        p.fetch = (s == S_FETCH);
        p.mem   = (s == S_MEM);
        p.wb    = (s == S_WB);
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
        p.stop  = (s == S_HALT) || (s == S_TRAP);
`else
        p.stop  = (s == S_HALT);
`endif
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_seq_fsm.sv
// ============================================================================
// Module : core_seq_fsm
// Brief  : Phase state register and next-state logic with registered one-hot
//          phase enables. Macro CORE_SEQ_MISALIGN_TRAP_EN adds the TRAP state.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module core_seq_fsm
    import core_seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_imem_ready,
    input  logic i_dmem_ready,
    input  logic i_is_load,
    input  logic i_is_store,
    input  logic i_is_halt,
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
    input  logic i_misalign,
`endif
    output logic o_fetch,
    output logic o_mem,
    output logic o_wb,
    output logic o_stop
);

    state_t r_state;
    state_t w_next;
    phase_t r_phase;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (i_imem_ready) w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (i_is_halt)                    w_next = S_HALT;
                else if (i_is_load || i_is_store) w_next = S_MEM;
                else                              w_next = S_WB;
            end
            S_MEM:    if (i_dmem_ready) w_next = S_WB;
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
            S_WB:     w_next = i_misalign ? S_TRAP : S_FETCH;
            S_TRAP:   w_next = S_TRAP;
`else
            S_WB:     w_next = S_FETCH;
`endif
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Enables are registered from the next state so they align with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_phase <= phase_of(S_FETCH);
        end else begin
            r_state <= w_next;
            r_phase <= phase_of(w_next);
        end
    end

    assign o_fetch = r_phase.fetch;
    assign o_mem   = r_phase.mem;
    assign o_wb    = r_phase.wb;
    assign o_stop  = r_phase.stop;

endmodule

`default_nettype wire

// File: rtl/core_seq.sv
// ============================================================================
// Module : core_seq
// Brief  : Multi-cycle RV32I sequencer owning PC, IR, MDR and instret, with
//          req/ready memory handshakes. Macro CORE_SEQ_MISALIGN_TRAP_EN
//          enables trapping on a misaligned next PC.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module core_seq
    import core_seq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(C_RESET_PC),
    parameter logic [31:0]     NOP      = C_NOP
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc,
    input  logic            is_load,
    input  logic            is_store,
    input  logic            is_halt,
    input  logic            reg_we,
    input  logic [XLEN-1:0] npc,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] mdr,
    output logic            rf_we,
    output logic [XLEN-1:0] instret,
    output logic            halted
);

    logic            w_fetch;
    logic            w_mem;
    logic            w_wb;
    logic            w_stop;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_mdr;
    logic [XLEN-1:0] r_instret;

`ifdef CORE_SEQ_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = |npc[1:0];
`endif

    core_seq_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .i_imem_ready (imem_ready),
        .i_dmem_ready (dmem_ready),
        .i_is_load    (is_load),
        .i_is_store   (is_store),
        .i_is_halt    (is_halt),
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
        .i_misalign   (w_misalign),
`endif
        .o_fetch      (w_fetch),
        .o_mem        (w_mem),
        .o_wb         (w_wb),
        .o_stop       (w_stop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= NOP;
            r_mdr     <= '0;
            r_instret <= '0;
        end else begin
            if (w_fetch && imem_ready) begin
                r_ir <= imem_rdata;
            end
            if (w_mem && dmem_ready && is_load) begin
                r_mdr <= dmem_rdata;
            end
            if (w_wb) begin
                r_instret <= r_instret + 1'b1;
`ifdef CORE_SEQ_MISALIGN_TRAP_EN
                if (!w_misalign) begin
                    r_pc <= npc;
                end
`else
                r_pc <= npc;
`endif
            end
        end
    end

    // The FETCH enable resets high, so the request is masked while reset is held.
    assign imem_req  = w_fetch & rst;
    assign imem_addr = r_pc;
    assign dmem_req  = w_mem;
    assign dmem_we   = w_mem & is_store;
    assign rf_we     = w_wb & reg_we;
    assign halted    = w_stop;
    assign ir        = r_ir;
    assign pc        = r_pc;
    assign mdr       = r_mdr;
    assign instret   = r_instret;

endmodule

`default_nettype wire
